// File: rtl/if_fetch_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage: the IF/ID payload
// handed to decode and the reset/stall/redirect encodings.
package if_fetch_stage_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int          PC_STEP      = 4;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
    } IF_ID_t;

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory request/response port. The fetch stage is the master; the
// memory (or its model) is the slave.
interface if_fetch_stage_if #(
    parameter int ADDR_W  = 32,
    parameter int INSTR_W = 32
);
    logic               req;
    logic [ADDR_W-1:0]  addr;
    logic               gnt;
    logic               rvalid;
    logic [INSTR_W-1:0] rdata;

    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);
endinterface

// File: rtl/if_fetch_stage_fetch_queue.sv
// Small power-of-two FIFO buffering fetched words between the imem response and
// the IF/ID register. Flush empties it in one cycle and wins over push/pop.
module if_fetch_stage_fetch_queue
    import if_fetch_stage_pkg::*;
#(
    parameter  int QDEPTH = 2,
    localparam int PTR_W  = $clog2(QDEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  IF_ID_t           push_data,
    output IF_ID_t           head,
    output logic [CNT_W-1:0] count
);

    IF_ID_t             mem_q [QDEPTH];
    IF_ID_t             mem_d [QDEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    // NOTE: combinational blocks assign every output a default first and use
    // blocking '=', so no latch is inferred; state flops update only with '<='.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: entry storage is deliberately not reset; an entry is only ever read
    // while count_q says it holds live data.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/if_fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, issues imem requests, tags them with
// an epoch so redirects kill stale responses, and drives the IF/ID register.
module if_fetch_stage
    import if_fetch_stage_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                INSTR_W  = 32,
    parameter int                QDEPTH   = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall_if,
    input  logic              stall_d,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    if_fetch_stage_if.master  imem,
    output IF_ID_t            ifid_o
);

    localparam int CNT_W = $clog2(QDEPTH) + 1;

    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic               inflight_q, inflight_d;
    logic               epoch_q, epoch_d;
    logic               tag_epoch_q, tag_epoch_d;
    logic [ADDR_W-1:0]  tag_pc_q, tag_pc_d;
    IF_ID_t             ifid_q, ifid_d;

    logic [CNT_W-1:0]   q_count;
    logic [CNT_W:0]     occupancy;
    IF_ID_t             q_head;
    IF_ID_t             push_data;
    logic [INSTR_W-1:0] rdata_w;
    logic               accept;
    logic               q_push;
    logic               q_pop;

    // Outstanding work (queued + in flight) must never exceed the queue depth,
    // which is what guarantees a push can never hit a full queue.
    assign occupancy = {1'b0, q_count} + (CNT_W + 1)'(inflight_q);
    assign imem.req  = (stall_if == DISABLE) && (redirect_valid == DISABLE) &&
                       (occupancy < (CNT_W + 1)'(QDEPTH));
    assign imem.addr = pc_q;
    assign accept    = imem.req && imem.gnt;
    assign rdata_w   = imem.rdata;

    assign q_push = imem.rvalid && inflight_q && (tag_epoch_q == epoch_q) &&
                    (redirect_valid == DISABLE);
    assign q_pop  = (redirect_valid == DISABLE) && (stall_d == DISABLE) &&
                    (q_count != '0);

    always_comb begin
        push_data.valid = 1'b1;
        push_data.pc    = tag_pc_q;
        push_data.pc4   = tag_pc_q + ADDR_W'(PC_STEP);
        push_data.instr = rdata_w;
    end

    always_comb begin
        pc_d        = pc_q;
        inflight_d  = inflight_q;
        epoch_d     = epoch_q;
        tag_epoch_d = tag_epoch_q;
        tag_pc_d    = tag_pc_q;
        ifid_d      = ifid_q;

        if (imem.rvalid && inflight_q) begin
            inflight_d = 1'b0;
        end
        if (accept) begin
            pc_d        = pc_q + ADDR_W'(PC_STEP);
            inflight_d  = 1'b1;
            tag_epoch_d = epoch_q;
            tag_pc_d    = pc_q;
        end

        // Redirect overrides everything else in the stage, including stall_d.
        if (redirect_valid == ENABLE) begin
            pc_d         = redirect_pc;
            epoch_d      = ~epoch_q;
            ifid_d.valid = 1'b0;
        end else if (stall_d == DISABLE) begin
            if (q_count != '0) begin
                ifid_d = q_head;
            end else begin
                ifid_d.valid = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            inflight_q  <= 1'b0;
            epoch_q     <= 1'b0;
            tag_epoch_q <= 1'b0;
            tag_pc_q    <= '0;
            ifid_q      <= '0;
        end else begin
            pc_q        <= pc_d;
            inflight_q  <= inflight_d;
            epoch_q     <= epoch_d;
            tag_epoch_q <= tag_epoch_d;
            tag_pc_q    <= tag_pc_d;
            ifid_q      <= ifid_d;
        end
    end

    if_fetch_stage_fetch_queue #(
        .QDEPTH (QDEPTH)
    ) u_fetch_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (q_push),
        .pop       (q_pop),
        .flush     (redirect_valid),
        .push_data (push_data),
        .head      (q_head),
        .count     (q_count)
    );

    assign ifid_o = ifid_q;

endmodule
